// File: rtl/phase_a_stream_ctrl_pkg.sv
// Shared sizes, state encoding and beat types for the phase_a host-side stream controller.
package phase_a_stream_ctrl_pkg;

    localparam int WIDTH  = 3072;
    localparam int WORD   = 64;
    localparam int NWORDS = WIDTH / WORD;
    localparam int CNT_W  = $clog2(NWORDS);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    typedef logic [WORD-1:0]             word_t;
    typedef logic [CNT_W-1:0]            cnt_t;
    typedef logic [NWORDS-1:0][WORD-1:0] opnd_t;

    typedef struct packed {
        word_t data;
        logic  last;
    } beat_t;

    function automatic logic is_last(input cnt_t c);
        return c == cnt_t'(NWORDS - 1);
    endfunction

endpackage

// File: rtl/phase_a_stream_ctrl_if.sv
// Word stream handshake shared by the operand input and result output sides.
interface phase_a_stream_ctrl_if;
    import phase_a_stream_ctrl_pkg::*;

    word_t data;
    logic  valid;
    logic  ready;
    logic  last;

    modport master (output data, output valid, output last, input  ready);
    modport slave  (input  data, input  valid, input  last, output ready);

endinterface

// File: rtl/phase_a_stream_ctrl_wide_word_mux.sv
// Result register captured from phase_a, read back one WORD slice at a time.
module wide_word_mux
    import phase_a_stream_ctrl_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  ld_i,
    input  opnd_t d_i,
    input  cnt_t  sel_i,
    output word_t q_o
);

    opnd_t res_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q <= '0;
        end else if (ld_i) begin
            res_q <= d_i;
        end
    end

    assign q_o = res_q[sel_i];

endmodule

// File: rtl/phase_a_stream_ctrl.sv
// Host-side controller for phase_a: gathers an operand word stream, pulses en,
// waits for en_out and streams the captured result back out.
module phase_a_stream_ctrl
    import phase_a_stream_ctrl_pkg::*;
#(
    parameter int TMO = 1023
) (
    input  logic                   clk,
    input  logic                   rst,
    phase_a_stream_ctrl_if.slave   in_i,
    phase_a_stream_ctrl_if.master  out_o,
    output logic [WIDTH-1:0]       a_o,
    output logic                   en_o,
    input  logic [WIDTH-1:0]       new_a_i,
    input  logic                   en_out_i,
    output logic                   busy_o,
    output logic                   err_o
);

    localparam int TMO_W = $clog2(TMO + 1);

    state_e           state_q;
    cnt_t             cnt_q;
    logic [TMO_W-1:0] tmo_q;
    opnd_t            a_q;
    logic             en_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             out_last_q;
    logic             busy_q;
    logic             err_q;

    logic in_fire;
    logic out_fire;
    logic capture;

    assign in_fire  = in_i.valid & in_ready_q;
    assign out_fire = out_valid_q & out_o.ready;
    assign capture  = (state_q == ST_WAIT) & en_out_i;

    // in_ready_q is only high in LOAD, so the operand cannot change once issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
        end else if (in_fire) begin
            a_q[cnt_q] <= in_i.data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            cnt_q       <= '0;
            tmo_q       <= '0;
            en_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (en_out_i && state_q != ST_WAIT) begin
                err_q <= 1'b1;
            end
            unique case (state_q)
                ST_LOAD: begin
                    if (in_fire) begin
                        if (is_last(cnt_q)) begin
                            cnt_q      <= '0;
                            state_q    <= ST_ISSUE;
                            en_q       <= 1'b1;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + cnt_t'(1);
                        end
                    end
                end
                ST_ISSUE: begin
                    en_q    <= 1'b0;
                    tmo_q   <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (en_out_i) begin
                        state_q     <= ST_DRAIN;
                        out_valid_q <= 1'b1;
                        out_last_q  <= is_last(cnt_q);
                    end else if (tmo_q == TMO_W'(TMO - 1)) begin
                        // Give up after TMO idle WAIT cycles; no result is emitted.
                        err_q      <= 1'b1;
                        state_q    <= ST_LOAD;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (out_fire) begin
                        if (is_last(cnt_q)) begin
                            cnt_q       <= '0;
                            state_q     <= ST_LOAD;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            in_ready_q  <= 1'b1;
                            busy_q      <= 1'b0;
                        end else begin
                            cnt_q      <= cnt_q + cnt_t'(1);
                            out_last_q <= is_last(cnt_q + cnt_t'(1));
                        end
                    end
                end
                default: state_q <= ST_LOAD;
            endcase
        end
    end

    wide_word_mux u_res (
        .clk   (clk),
        .rst   (rst),
        .ld_i  (capture),
        .d_i   (new_a_i),
        .sel_i (cnt_q),
        .q_o   (out_o.data)
    );

    assign in_i.ready  = in_ready_q;
    assign out_o.valid = out_valid_q;
    assign out_o.last  = out_last_q;
    assign a_o         = a_q;
    assign en_o        = en_q;
    assign busy_o      = busy_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_phase_a_stream_ctrl.sv
// Scoreboard bench for phase_a_stream_ctrl with a fixed-latency phase_a stub returning ~a.
module tb_phase_a_stream_ctrl;
    import phase_a_stream_ctrl_pkg::*;

    localparam int LAT = 10;
    localparam int TMO = 1023;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] a;
    logic             en;
    logic [WIDTH-1:0] new_a = '0;
    logic             en_out = 1'b0;
    logic             busy;
    logic             err;

    phase_a_stream_ctrl_if in_if ();
    phase_a_stream_ctrl_if out_if ();

    phase_a_stream_ctrl #(.TMO(TMO)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_i     (in_if),
        .out_o    (out_if),
        .a_o      (a),
        .en_o     (en),
        .new_a_i  (new_a),
        .en_out_i (en_out),
        .busy_o   (busy),
        .err_o    (err)
    );

    initial forever #5 clk = ~clk;

    int    cyc = 0;
    int    errors = 0;
    int    checks = 0;
    int    last_in_cyc = -100;
    int    en_cyc = -100;
    int    en_cnt = 0;
    int    enout_cyc = -100;
    int    n_acc = 0;
    int    rdy_mode = 0;
    bit    stub_silent = 1'b0;
    beat_t exp_q[$];
    opnd_t exp_a_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic word_t pat(input int p, input int k);
        if (p == 0) return word_t'(k);
        return {8'(p), 8'h5A, 16'(k), 32'(k) * 32'h9E37_79B9};
    endfunction

    // Downstream ready: 0 = always ready, 1 = random 50%, 2 = stalled.
    initial begin
        out_if.ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       out_if.ready = 1'b1;
                1:       out_if.ready = 1'($urandom_range(0, 1));
                default: out_if.ready = 1'b0;
            endcase
        end
    end

    // phase_a stub: answers each en with ~a after LAT cycles.
    initial begin
        logic [WIDTH-1:0] cap;
        forever begin
            @(negedge clk);
            if (en && !stub_silent && !rst) begin
                cap = a;
                repeat (LAT) @(posedge clk);
                #1;
                new_a     = ~cap;
                en_out    = 1'b1;
                enout_cyc = cyc;
                @(posedge clk);
                #1;
                en_out = 1'b0;
            end
        end
    end

    // Monitor: en pulses, operand contents, result beats and their stability.
    initial begin
        bit    en_prev = 1'b0;
        bit    vld_prev = 1'b0;
        bit    hold_v = 1'b0;
        word_t hold_d = '0;
        forever begin
            @(negedge clk);
            if (in_if.valid && in_if.ready && !rst) last_in_cyc = cyc;
            if (en) begin
                en_cnt++;
                en_cyc = cyc;
                chk("en_single_pulse", 64'(en_prev), 64'd0);
                chk("en_latency", 64'(cyc), 64'(last_in_cyc + 1));
                if (exp_a_q.size() == 0) begin
                    chk("unexpected_en", 64'd1, 64'd0);
                end else begin
                    opnd_t e;
                    e = exp_a_q.pop_front();
                    for (int w = 0; w < NWORDS; w++) chk("a_word", a[w*WORD +: WORD], e[w]);
                end
            end
            en_prev = en;
            if (out_if.valid) begin
                if (!vld_prev) chk("first_out_latency", 64'(cyc), 64'(enout_cyc + 1));
                if (hold_v) chk("out_stable", out_if.data, hold_d);
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 64'd1, 64'd0);
                end else if (out_if.ready) begin
                    beat_t b;
                    b = exp_q.pop_front();
                    chk("out_data", out_if.data, b.data);
                    chk("out_last", 64'(out_if.last), 64'(b.last));
                    n_acc++;
                end
                hold_v = !out_if.ready;
                hold_d = out_if.data;
            end else begin
                hold_v = 1'b0;
            end
            vld_prev = out_if.valid;
        end
    end

    // Entered and left at posedge+1.
    task automatic send_words(input int p, input int n, input bit gaps);
        for (int k = 0; k < n; k++) begin
            int t;
            if (gaps) begin
                in_if.valid = 1'b0;
                @(posedge clk);
                #1;
            end
            in_if.data  = pat(p, k);
            in_if.valid = 1'b1;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!in_if.ready && t < 3000);
            if (!in_if.ready) chk("in_ready_timeout", 64'd0, 64'd1);
            @(posedge clk);
            #1;
        end
        in_if.valid = 1'b0;
    endtask

    task automatic issue_op(input int p, input bit with_out, input bit gaps);
        opnd_t e;
        for (int k = 0; k < NWORDS; k++) begin
            e[k] = pat(p, k);
            if (with_out) exp_q.push_back('{data: ~pat(p, k), last: (k == NWORDS - 1)});
        end
        exp_a_q.push_back(e);
        send_words(p, NWORDS, gaps);
    endtask

    task automatic wait_done();
        int t = 0;
        while ((exp_q.size() != 0 || busy) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("transaction_done", 64'(exp_q.size() == 0 && !busy), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        exp_a_q.delete();
    endtask

    task automatic chk_idle(input string nm);
        @(negedge clk);
        chk({nm, "_in_ready"}, 64'(in_if.ready), 64'd1);
        chk({nm, "_en"}, 64'(en), 64'd0);
        chk({nm, "_out_valid"}, 64'(out_if.valid), 64'd0);
        chk({nm, "_busy"}, 64'(busy), 64'd0);
        chk({nm, "_err"}, 64'(err), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int t;
        int e;
        in_if.valid = 1'b0;
        in_if.data  = '0;
        in_if.last  = 1'b0;

        // 1: reset
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_idle("reset");

        // 2: back-to-back words, ready always high
        rdy_mode = 0;
        issue_op(0, 1'b1, 1'b0);
        wait_done();

        // 3: bubbles on input, random downstream stalls
        rdy_mode = 1;
        issue_op(0, 1'b1, 1'b1);
        wait_done();
        rdy_mode = 0;

        // 5: stray en_out while idle
        @(negedge clk);
        chk("err_before_stray", 64'(err), 64'd0);
        @(posedge clk);
        #1;
        new_a  = {WIDTH{1'b1}};
        en_out = 1'b1;
        @(posedge clk);
        #1;
        en_out = 1'b0;
        @(negedge clk);
        chk("err_after_stray", 64'(err), 64'd1);
        chk("stray_out_valid", 64'(out_if.valid), 64'd0);
        chk("stray_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        issue_op(2, 1'b1, 1'b0);
        wait_done();

        // 6a: reset after 20 operand words
        do_reset();
        send_words(6, 20, 1'b0);
        do_reset();
        chk_idle("rst_mid_load");
        issue_op(7, 1'b1, 1'b0);
        wait_done();

        // 6b: reset while word 5 is presented
        issue_op(8, 1'b1, 1'b0);
        base = n_acc;
        t = 0;
        while (n_acc - base < 5 && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_reached_word5", 64'(n_acc - base), 64'd5);
        rdy_mode = 2;
        do_reset();
        rdy_mode = 0;
        chk_idle("rst_mid_drain");
        repeat (30) @(posedge clk);
        #1;
        issue_op(9, 1'b1, 1'b0);
        wait_done();

        // 4: phase_a never answers
        do_reset();
        stub_silent = 1'b1;
        base = en_cnt;
        issue_op(4, 1'b0, 1'b0);
        t = 0;
        while (en_cnt == base && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("tmo_en_seen", 64'(en_cnt - base), 64'd1);
        e = en_cyc;
        while (cyc < e + TMO) @(negedge clk);
        chk("tmo_err_before", 64'(err), 64'd0);
        chk("tmo_busy_before", 64'(busy), 64'd1);
        @(negedge clk);
        chk("tmo_err_after", 64'(err), 64'd1);
        chk("tmo_busy_after", 64'(busy), 64'd0);
        chk("tmo_in_ready_after", 64'(in_if.ready), 64'd1);
        repeat (20) @(negedge clk);
        chk("tmo_no_out_valid", 64'(out_if.valid), 64'd0);
        chk("exp_a_queue_empty", 64'(exp_a_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
